// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I byte/half/word loads and stores onto a word-wide memory.
//               Sub-word stores use read-modify-write. Optional macro
//               LSU_MISALIGN_TRAP_EN makes misaligned accesses fault.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic [31:0]       mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RMW_WR = 2'd1,
        S_RESP   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_half;
    logic [15:0]       r_wdata;
    logic [31:0]       r_merge;
    logic [31:0]       r_rdata;

    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_legal;
    logic              w_misalign;
    logic              w_fault;
    logic [1:0]        w_off;
    logic              w_accept;
    logic              w_sw;
    logic [7:0]        w_byte;
    logic [15:0]       w_hword;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_is_byte  = (funct3[1:0] == 2'b00);
    assign w_is_half  = (funct3[1:0] == 2'b01);
    assign w_is_word  = (funct3[1:0] == 2'b10);
    assign w_legal    = store ? (!funct3[2] && (funct3[1:0] != 2'b11))
                              : ((funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]));
    assign w_misalign = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_fault = !w_legal || w_misalign;
`else
    assign w_fault = !w_legal;
`endif

    // Effective lane offset; in the non-trapping build misaligned bits are dropped.
    assign w_off = w_is_word ? 2'b00 :
                   w_is_half ? {addr[1], 1'b0} : addr[1:0];

    assign w_accept = (r_state == S_IDLE) && req;
    assign w_sw     = store && w_is_word && !w_fault;

    always_comb begin
        w_byte = 8'h00;
        case (w_off)
            2'b00: w_byte = mem_rd[7:0];
            2'b01: w_byte = mem_rd[15:8];
            2'b10: w_byte = mem_rd[23:16];
            2'b11: w_byte = mem_rd[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_hword = w_off[1] ? mem_rd[31:16] : mem_rd[15:0];

    always_comb begin
        w_load = mem_rd;
        case (funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_hword[15]}}, w_hword};
            3'b100:  w_load = {24'h000000, w_byte};
            3'b101:  w_load = {16'h0000, w_hword};
            default: w_load = mem_rd;
        endcase
    end

    always_comb begin
        w_merged = r_merge;
        if (r_half) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    assign w_mem_addr = (r_state == S_IDLE) ? addr : r_addr;
    assign mem_a      = 32'({w_mem_addr[ADDR_W-1:2], 2'b00});
    assign mem_we     = (r_state == S_RMW_WR) || (w_accept && w_sw);
    assign mem_wd     = (r_state == S_RMW_WR) ? w_merged : wdata;

    assign ready = (r_state == S_IDLE);
    assign done  = (r_state == S_RESP) || (r_state == S_FAULT);
    assign fault = (r_state == S_FAULT);
    assign rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_half  <= 1'b0;
            r_wdata <= 16'h0000;
            r_merge <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        // Low address bits are stored already aligned to the lane offset.
                        r_addr  <= {addr[ADDR_W-1:2], w_off};
                        r_half  <= w_is_half;
                        r_wdata <= wdata[15:0];
                        if (w_fault) begin
                            r_state <= S_FAULT;
                        end else if (store) begin
                            if (w_is_byte || w_is_half) begin
                                r_merge <= mem_rd;
                                r_state <= S_RMW_WR;
                            end else begin
                                r_state <= S_RESP;
                            end
                        end else begin
                            r_rdata <= w_load;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RMW_WR: r_state <= S_RESP;
                S_RESP:   r_state <= S_IDLE;
                S_FAULT:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Testbench for load_store_unit: directed accesses against a word memory model,
// responses checked by a scoreboard monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, fault, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:127];
    int          cyc = 0;
    int          we_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        logic        f;
        logic        chk;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sb[$];

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .store(store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .fault(fault),
        .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[8:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_a[8:2]] <= mem_wd;
    end

    always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no response (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc, e.c);
                chk("fault", {31'b0, fault}, {31'b0, e.f});
                if (e.chk) chk("rdata", rdata, e.d);
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic ef,
                         input logic ck, input logic [31:0] ed, input logic hold);
        int n;
        exp_t e;
        @(negedge clk);
        chk("ready_before_req", {31'b0, ready}, 32'd1);
        store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
        e.f = ef; e.chk = ck; e.d = ed; e.c = cyc + lat;
        sb.push_back(e);
        if (ck && !ef) last_rd = ed;
        @(posedge clk);
        #1;
        if (hold) begin
            // A second request presented while busy must be ignored.
            store = 1'b1; funct3 = 3'b010; addr = 32'h108; wdata = 32'h1111_1111;
            repeat (lat) @(posedge clk);
            #1;
        end
        req = 1'b0; store = 1'b0; funct3 = 3'b111; addr = 32'h3C; wdata = 32'hA5A5_A5A5;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 8);
        if (!ready) chk("ready_timeout", {31'b0, ready}, 32'd1);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8899_AABB;

        repeat (2) @(negedge clk);
        chk("rst_ready",  {31'b0, ready},  32'd1);
        chk("rst_done",   {31'b0, done},   32'd0);
        chk("rst_fault",  {31'b0, fault},  32'd0);
        chk("rst_rdata",  rdata,           32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        rst = 1'b0;

        issue(1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 1'b1, 32'hFFFF_FF88, 1'b0); // LB
        issue(1'b0, 3'b100, 32'h103, 32'h0, 1, 1'b0, 1'b1, 32'h0000_0088, 1'b0); // LBU
        issue(1'b0, 3'b101, 32'h102, 32'h0, 1, 1'b0, 1'b1, 32'h0000_8899, 1'b0); // LHU

        // SB 0x101 <- CC with cycle-level write checks
        @(negedge clk);
        store = 1'b1; funct3 = 3'b000; addr = 32'h101; wdata = 32'h0000_00CC; req = 1'b1;
        sb.push_back('{f: 1'b0, chk: 1'b0, d: 32'h0, c: cyc + 2});
        #1;
        chk("sb_accept_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0; wdata = 32'hFFFF_FFFF; addr = 32'h0;
        @(negedge clk);
        chk("sb_rmw_we", {31'b0, mem_we}, 32'd1);
        chk("sb_rmw_wd", mem_wd, 32'h8899_CCBB);
        chk("sb_rmw_a",  mem_a,  32'h0000_0100);
        repeat (2) @(negedge clk);
        chk("sb_mem_word", mem[32'h100 >> 2], 32'h8899_CCBB);

        issue(1'b1, 3'b010, 32'h100, 32'h8899_AABB, 1, 1'b0, 1'b0, 32'h0, 1'b0); // SW restore
        w0 = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 32'h101, 32'h0, 1, 1'b1, 1'b1, last_rd, 1'b0);      // LH misaligned
        chk("lh_misalign_no_we", we_cnt, w0);
`else
        issue(1'b0, 3'b001, 32'h101, 32'h0, 1, 1'b0, 1'b1, 32'hFFFF_AABB, 1'b0);
`endif
        issue(1'b1, 3'b001, 32'h102, 32'h0000_1234, 2, 1'b0, 1'b0, 32'h0, 1'b0); // SH
        chk("sh_mem_word", mem[32'h100 >> 2], 32'h1234_AABB);

        issue(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'h0, 1'b0); // SW
        issue(1'b0, 3'b010, 32'h104, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1); // LW + held req
        chk("busy_req_ignored", mem[32'h108 >> 2], 32'h0);

        w0 = we_cnt;
        issue(1'b0, 3'b011, 32'h104, 32'h0, 1, 1'b1, 1'b1, last_rd, 1'b0);          // illegal load
        issue(1'b1, 3'b100, 32'h104, 32'h0000_0077, 1, 1'b1, 1'b0, 32'h0, 1'b0);   // illegal store
        chk("illegal_no_we", we_cnt, w0);
        chk("illegal_store_mem", mem[32'h104 >> 2], 32'hDEAD_BEEF);

        // Reset during RMW_WR of SB 0x100 <- 0x55
        @(negedge clk);
        store = 1'b1; funct3 = 3'b000; addr = 32'h100; wdata = 32'h0000_0055; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        chk("rst_rmw_we_before", {31'b0, mem_we}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_rmw_we_drop", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rmw_mem", mem[32'h100 >> 2], 32'h1234_AABB);
        chk("post_rst_ready", {31'b0, ready},  32'd1);
        chk("post_rst_done",  {31'b0, done},   32'd0);
        chk("post_rst_fault", {31'b0, fault},  32'd0);
        chk("post_rst_rdata", rdata,           32'd0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and `data_memory`. It turns RV32I byte, halfword and word loads and stores into word-wide memory accesses, because the memory has only a 32-bit write port. Sub-word stores use a two-cycle read-modify-write. Loads are sign- or zero-extended and returned through a registered response. A simple ready/done handshake stalls the core while an access is in flight.

## Interface
- `ADDR_W`, 32, byte-address width; the memory-side address is word-aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; accepted only when `ready`=1.
- `store`  in  1  1=store, 0=load; sampled with `req`.
- `funct3`  in  3  RV32I size/sign code; sampled with `req`.
- `addr`  in  ADDR_W  byte address; sampled with `req`.
- `wdata`  in  32  store data, right-aligned; sampled with `req`.
- `ready`  out  1  1 when idle and able to accept `req`.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  qualifies `done`: access rejected, no memory side effect.
- `rdata`  out  32  extended load data, valid while `done`=1 for a load.
- `mem_a`  out  32  byte address to memory, `{addr[31:2],2'b00}`.
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data; combinational from `mem_a`.

## Operation
- The FSM has four states: IDLE, RMW_WR, RESP, FAULT.
- Request latching:
  - `req` is accepted in IDLE only.
  - At acceptance, `store`, `funct3`, `addr` and `wdata` are captured into internal registers.
  - The core need not hold its inputs after acceptance.
- `mem_a` selection:
  - In IDLE, `mem_a` is driven from the live `addr`.
  - In all other states, `mem_a` is driven from the latched address.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal. IDLE→FAULT; no memory access.
- Load:
  - In IDLE, `mem_rd` is sampled at the accept edge.
  - The byte or halfword is selected by `addr[1:0]` in little-endian order.
  - It is sign-extended (LB/LH) or zero-extended (LBU/LHU) into `rdata`.
  - IDLE→RESP.
- SW: `mem_we`=1 and `mem_wd`=`wdata` in the accept cycle. The word is written at that edge; IDLE→RESP.
- SB/SH read-modify-write:
  - Accept cycle: `mem_we`=0. `mem_rd` is captured into a merge register at the edge. IDLE→RMW_WR.
  - RMW_WR: `mem_we`=1. `mem_wd` is the merge word with the selected byte or halfword lanes replaced by `wdata[7:0]` or `wdata[15:0]`. RMW_WR→RESP.
- RESP: `done`=1, `fault`=0. RESP→IDLE.
- FAULT: `done`=1, `fault`=1, `rdata` unchanged. FAULT→IDLE.
- `mem_we` is decoded from the state and the live request:
  - It is 1 only during a SW accept cycle or in RMW_WR.
  - It is never 1 for a faulting access.

## Timing
- `ready` = (state==IDLE), combinational.
- Latency from the accept edge to `done`:
  - Loads, SW and faults: 1 cycle.
  - SB and SH: 2 cycles.
- Throughput: one access per 2 cycles; SB/SH one per 3 cycles.
- `done` is high for exactly one cycle per accepted request and is never asserted without a prior accept.
- `req` while `ready`=0 is ignored. The request is neither queued nor errored.
- Reset values: state IDLE; `done` 0; `fault` 0; `rdata` 0; `mem_we` 0; latched address, data and merge registers 0.
- Reset asserted mid-operation:
  - `mem_we` drops asynchronously with the state.
  - An in-flight SB/SH in RMW_WR performs no write; the memory word is left unchanged.
  - No `done` is issued for the aborted request.
- Simultaneous `done` and `req`: in RESP or FAULT `ready`=0, so the new `req` is accepted only on the following cycle.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Misaligned accesses:
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠00.
- Defined: a misaligned access goes IDLE→FAULT with no memory access.
- Undefined: misaligned low bits are forced to alignment and the access proceeds normally.
  - Halfword uses `{addr[1],1'b0}`.
  - Word uses `2'b00`.
- Illegal funct3 faults in both builds.

## Test plan
- Memory word 0x100 = 0x8899AABB. LB at 0x103 → `done` one cycle after accept, `rdata`=0xFFFFFF88. LBU at 0x103 → 0x00000088. LHU at 0x102 → 0x00008899.
- SB at 0x101 with `wdata`=0x000000CC:
  - Accept cycle: `mem_we`=0.
  - Next cycle: `mem_we`=1, `mem_wd`=0x8899CCBB.
  - `done` on the second cycle after accept; word afterwards reads 0x8899CCBB.
- SH at 0x102 with `wdata`=0x00001234 → word 0x1234AABB. Then SW at 0x104 with 0xDEADBEEF followed by LW at 0x104 → `rdata`=0xDEADBEEF.
- LH at 0x101:
  - With `LSU_MISALIGN_TRAP_EN`: `done`=1, `fault`=1 one cycle after accept; `mem_we` never asserted.
  - Without it: `rdata`=0xFFFFAABB.
- Load with funct3=011 → `fault`=1. Store with funct3=100 → `fault`=1 and memory unchanged.
- `rst` pulsed while in RMW_WR of SB 0x100/0x55 → `mem_we` falls immediately, no `done`, word 0x100 unchanged. `ready`=1 and outputs at reset values after release.
